// File: rtl/dmem_bus_arbiter.sv
// Data-memory port arbiter: MEM stage (default priority) vs. UART DMA loader.
// Define DMEM_ARB_STARVE_GUARD_EN to add the starvation counter and FORCE slot.
module dmem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (1 << CNT_W) - 1) begin : g_bad_cfg
    $error("STARVE_LIMIT must be >= 1 and fit in CNT_W bits");
  end

  logic cpu_act;
  logic dma_grant;
  logic force_slot;
  logic rd_grant;

  assign cpu_act  = cpu_rd | cpu_wr;
  assign rd_grant = dma_grant & ~dma_we;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  typedef enum logic {
    IDLE,
    FORCE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             blocked;
  logic             starve_hit;

  assign force_slot = (state == FORCE);
  assign blocked    = dma_valid & ~dma_grant;
  assign starve_hit = blocked &&
    (starve_cnt == CNT_W'(STARVE_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        IDLE:    state <= starve_hit ? FORCE : IDLE;
        FORCE:   state <= IDLE;
        default: state <= IDLE;
      endcase
      // Counter clears when the forced slot is scheduled.
      if (!blocked || starve_hit)
        starve_cnt <= '0;
      else if (starve_cnt < CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_slot = 1'b0;
`endif

  always_comb begin
    dma_grant = 1'b0;
    cpu_stall = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (force_slot) begin
      // A dropped request in FORCE leaves the port idle.
      if (dma_valid) begin
        dma_grant = 1'b1;
        cpu_stall = cpu_act;
      end
    end else if (cpu_act) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_valid) begin
      dma_grant = 1'b1;
    end
    if (dma_grant) begin
      mem_rd    = ~dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign dma_ready = dma_grant;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= rd_grant;
      if (rd_grant)
        dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: vector table, DMA read scoreboard, corner sequences.
// Build with DMEM_ARB_STARVE_GUARD_EN to exercise the FORCE slot.
module tb_dmem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_valid, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ready;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

  dmem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_valid(dma_valid), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [31:0] caddr, cwdata;
    logic        dv, dwe;
    logic [31:0] daddr, dwdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr;
    logic        e_ready;
    logic        chk_crd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [31:0] ca, input logic [31:0] cw,
                       input logic dv, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dw);
    @(negedge clk);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = ca;
    cpu_wdata = cw;
    dma_valid = dv;
    dma_we    = dwe;
    dma_addr  = da;
    dma_wdata = dw;
    #1;
  endtask

  task automatic check_rvalid(input string n, input logic e);
    logic [31:0] exp_d;
    chk({n, ":rvalid"}, {31'b0, dma_rvalid}, {31'b0, e});
    if (dma_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s:sb_empty got rvalid expected none", n);
      end else begin
        exp_d = sb.pop_front();
        chk({n, ":rdata"}, dma_rdata, exp_d);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    logic rg;
    drive(v.rd, v.wr, v.caddr, v.cwdata, v.dv, v.dwe, v.daddr, v.dwdata);
    chk({v.name, ":mem_rd"}, {31'b0, mem_rd}, {31'b0, v.e_rd});
    chk({v.name, ":mem_wr"}, {31'b0, mem_wr}, {31'b0, v.e_wr});
    chk({v.name, ":mem_addr"}, mem_addr, v.e_addr);
    chk({v.name, ":ready"}, {31'b0, dma_ready}, {31'b0, v.e_ready});
    chk({v.name, ":stall"}, {31'b0, cpu_stall}, 32'd0);
    if (v.chk_crd) chk({v.name, ":cpu_rdata"}, cpu_rdata, v.e_data);
    rg = v.e_ready & ~v.dwe;
    if (rg) sb.push_back(v.e_data);
    @(posedge clk);
    #1;
    check_rvalid(v.name, rg);
  endtask

  task automatic starve_cycles(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      drive(1'b0, 1'b1, 32'h80, 32'(c), 1'b1, 1'b1, 32'h84, 32'h5555);
      chk({tag, ":blk_ready"}, {31'b0, dma_ready}, 32'd0);
      chk({tag, ":blk_stall"}, {31'b0, cpu_stall}, 32'd0);
      @(posedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    vecs[0]  = '{"idle", 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h0, 0, 0, 0};
    vecs[1]  = '{"dma_wr40", 0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF,
                 0, 1, 32'h40, 1, 0, 0};
    vecs[2]  = '{"dma_rd40", 0, 0, 0, 0, 1, 0, 32'h40, 0,
                 1, 0, 32'h40, 1, 0, 32'hDEADBEEF};
    vecs[3]  = '{"cpu_rd10_vs_dma", 1, 0, 32'h10, 0, 1, 0, 32'h44, 0,
                 1, 0, 32'h10, 0, 1, 32'h0};
    vecs[4]  = '{"cpu_wr44_vs_dma", 0, 1, 32'h44, 32'h12345678,
                 1, 0, 32'h44, 0, 0, 1, 32'h44, 0, 0, 0};
    vecs[5]  = '{"dma_rd44", 0, 0, 0, 0, 1, 0, 32'h44, 0,
                 1, 0, 32'h44, 1, 0, 32'h12345678};
    vecs[6]  = '{"dma_rd40_b2b", 0, 0, 0, 0, 1, 0, 32'h40, 0,
                 1, 0, 32'h40, 1, 0, 32'hDEADBEEF};
    vecs[7]  = '{"dma_wr48", 0, 0, 0, 0, 1, 1, 32'h48, 32'hA5A5A5A5,
                 0, 1, 32'h48, 1, 0, 0};
    vecs[8]  = '{"cpu_rd48", 1, 0, 32'h48, 0, 0, 0, 0, 0,
                 1, 0, 32'h48, 0, 1, 32'hA5A5A5A5};
    vecs[9]  = '{"cpu_wr4c", 0, 1, 32'h4C, 32'h1, 0, 0, 0, 0,
                 0, 1, 32'h4C, 0, 0, 0};
    vecs[10] = '{"idle_end", 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h0, 0, 0, 0};

    reset = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_valid = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst:mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst:mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    chk("rst:ready", {31'b0, dma_ready}, 32'd0);
    chk("rst:stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst:rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("rst:rdata", dma_rdata, 32'd0);

    for (int i = 0; i < 11; i++) apply(vecs[i]);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    starve_cycles(8, "starve1");
    drive(1'b0, 1'b1, 32'h80, 32'h9, 1'b1, 1'b1, 32'h84, 32'h5555);
    chk("force:ready", {31'b0, dma_ready}, 32'd1);
    chk("force:stall", {31'b0, cpu_stall}, 32'd1);
    chk("force:mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("force:mem_addr", mem_addr, 32'h84);
    @(posedge clk);
    #1;
    check_rvalid("force", 1'b0);
    drive(1'b0, 1'b1, 32'h80, 32'hA, 1'b1, 1'b1, 32'h84, 32'h5555);
    chk("after_force:ready", {31'b0, dma_ready}, 32'd0);
    chk("after_force:stall", {31'b0, cpu_stall}, 32'd0);
    chk("after_force:mem_addr", mem_addr, 32'h80);
    @(posedge clk);
    starve_cycles(7, "starve2");
    drive(1'b0, 1'b1, 32'h80, 32'hB, 1'b1, 1'b1, 32'h84, 32'h5555);
    reset = 1'b1;
    #1;
    chk("rst_force:ready", {31'b0, dma_ready}, 32'd1);
    @(posedge clk);
    drive(1'b0, 1'b1, 32'h80, 32'hC, 1'b1, 1'b1, 32'h84, 32'h5555);
    reset = 1'b0;
    #1;
    chk("rst_force:idle_ready", {31'b0, dma_ready}, 32'd0);
    chk("rst_force:idle_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk);
    starve_cycles(7, "starve3");
    drive(1'b0, 1'b1, 32'h80, 32'hD, 1'b0, 1'b1, 32'h84, 32'h5555);
    chk("drop:ready", {31'b0, dma_ready}, 32'd0);
    chk("drop:stall", {31'b0, cpu_stall}, 32'd0);
    chk("drop:mem_wr", {31'b0, mem_wr}, 32'd0);
    @(posedge clk);
    drive(1'b0, 1'b1, 32'h80, 32'hE, 1'b1, 1'b1, 32'h84, 32'h5555);
    chk("drop:idle_ready", {31'b0, dma_ready}, 32'd0);
    chk("drop:idle_mem_addr", mem_addr, 32'h80);
    @(posedge clk);
`else
    for (int c = 0; c < 100; c++) begin
      drive(1'b0, 1'b1, 32'h80, 32'(c), 1'b1, 1'b1, 32'h84, 32'h5555);
      chk("noguard:ready", {31'b0, dma_ready}, 32'd0);
      chk("noguard:stall", {31'b0, cpu_stall}, 32'd0);
      @(posedge clk);
    end
`endif

    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'h40, 0);
    chk("rst_rd:ready", {31'b0, dma_ready}, 32'd1);
    sb.push_back(32'hDEADBEEF);
    @(posedge clk);
    #1;
    check_rvalid("rst_rd:grant", 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rd:rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("rst_rd:rdata", dma_rdata, 32'd0);
    drive(1'b0, 1'b1, 32'h80, 32'h1, 1'b1, 1'b1, 32'h84, 32'h2);
    reset = 1'b0;
    #1;
    chk("rst_rd:idle_ready", {31'b0, dma_ready}, 32'd0);
    chk("rst_rd:idle_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);

    chk("sb:leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
